fc_in_buffer: RTL and testbench
===============================

// Module: fc_in_buffer
// PURPOSE
// - Upstream feeder for the constant-weight FC neuron layers (booth multiplier + adder tree + ReLU).
// - Collects a serial stream of WIDTH-bit activations into an IN-entry vector x[0:IN-1].
// - Presents the vector, held stable, to all neurons of the layer in parallel.
// - Ping-pong (2-bank) buffer: frame n+1 loads while frame n is held for the combinational layer and its result register.
// PARAMETERS
// - WIDTH  8    activation width; matches the neuron layer's WIDTH
// - IN     128  activations per frame; matches the layer's IN
// PORTS
// - clk      in   1          single clock; all logic on rising edge
// - rst      in   1          synchronous, active-high reset
// - s_valid  in   1          upstream activation valid
// - s_ready  out  1          buffer can accept an activation
// - s_data   in   WIDTH      activation value (two's complement, passed unmodified)
// - s_last   in   1          end-of-frame marker; port exists only with FC_IN_LAST_CHECK_EN
// - m_valid  out  1          x holds a complete frame
// - m_ready  in   1          downstream has captured the layer result; release the frame
// - x        out  WIDTH x IN unpacked array [WIDTH-1:0] x[0:IN-1], read-bank contents
// - err      out  1          sticky framing error; present only with FC_IN_LAST_CHECK_EN
// BEHAVIOUR
// - State: wr_bank, rd_bank (1b each), wr_cnt ($clog2(IN)b), full[1:0].
// - Reset: wr_bank=rd_bank=0, wr_cnt=0, full=2'b00, err=0.
//   - Outputs: m_valid=0, s_ready=0 while rst=1, s_ready=1 the first cycle after.
//   - Bank data not reset; x is don't-care while m_valid=0.
// - Write accept = s_valid & s_ready. s_ready = ~full[wr_bank] & ~rst, driven from registers only.
// - Each accept: bank[wr_bank][wr_cnt] <= s_data; wr_cnt++.
//   - Entry k of a frame lands in x[k]; first accepted word is x[0].
// - Accept at wr_cnt==IN-1 (frame close): full[wr_bank]<=1, wr_cnt<=0, wr_bank toggles.
//   - Wrap is exact; wr_cnt never reaches IN.
// - m_valid = full[rd_bank]. x = bank[rd_bank]; constant while m_valid=1 until release.
// - Release = m_valid & m_ready: full[rd_bank]<=0, rd_bank toggles.
// - Latency: frame-closing accept at edge t -> m_valid=1 after edge t (if that bank is rd_bank).
//   - Same-cycle closing accept and release are both honoured.
//   - Release of the old bank plus close of the other -> m_valid stays 1; x switches to the new frame.
// - Both banks full -> s_ready=0. Release at edge t -> s_ready=1 after t. No combinational m_ready->s_ready path.
// - s_valid while s_ready=0: ignored, no state change; upstream holds data.
// - m_ready while m_valid=0: ignored.
// - rst mid-frame: partial frame discarded, both banks emptied, counters cleared.
// CONFIGURATION
// - FC_IN_LAST_CHECK_EN defined: s_last and err exist.
//   - s_last=1 accepted at wr_cnt<IN-1: remaining entries of that bank are zero-written.
//     - One entry per cycle; s_ready=0 during fill.
//     - Frame closes after the fill; err<=1.
//   - Accept at wr_cnt==IN-1 with s_last=0: frame closes normally, err<=1.
//   - err is cleared only by rst.
// - Undefined: no s_last/err ports; framing purely by count. Zero-fill logic absent.
// TESTING
// - Reset, then stream 0..127 back-to-back, m_ready=0 -> m_valid rises the cycle after word 127; x[k]=k.
// - Continue 128 more words (value 8'h80+k[6:0]) with m_ready=0.
//   - Second bank fills; s_ready=0 after its last word.
//   - m_valid=1; x still holds frame 0.
// - Then m_ready=1 for 1 cycle -> x shows frame 1 next cycle, m_valid stays 1, s_ready=1 next cycle.
// - Random s_valid gaps (50%) and m_ready throttling over 20 frames -> every frame delivered in order, no lost/duplicated word.
// - Closing accept and release in same cycle -> no bubble on m_valid, bank pointers consistent.
// - rst at wr_cnt=60 of frame 2 with one full bank -> m_valid=0, s_ready=1 after reset.
//   - Next 128 words form a clean frame at x[0..127].
// - With FC_IN_LAST_CHECK_EN: s_last on word 99 -> x[100..127]=0, err=1.
//   - Correct s_last on word 127 -> err unchanged.

Source files
------------

// File: rtl/fc_in_buffer.sv
// Ping-pong activation buffer: collects IN serial WIDTH-bit words per frame and holds the frame stable for the FC layer.
// Optional framing check (s_last, err, zero-fill of short frames) enabled by defining FC_IN_LAST_CHECK_EN.
module fc_in_buffer #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
`ifdef FC_IN_LAST_CHECK_EN
  input  logic             s_last,
  output logic             err,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] x [0:IN-1]
);

  localparam int CW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

  logic             wr_bank;
  logic             rd_bank;
  logic [CW-1:0]    wr_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic [WIDTH-1:0] bank0 [0:IN-1];
  logic [WIDTH-1:0] bank1 [0:IN-1];

  logic             accept;
  logic             rel;
  logic             we;
  logic             close;
  logic [WIDTH-1:0] wdata;

`ifdef FC_IN_LAST_CHECK_EN
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0] state;
  logic       filling;

  assign filling = (state == ST_FILL);
  assign s_ready = ~full[wr_bank] & ~filling & ~rst;
  assign accept  = s_valid & s_ready;
  // Zero-fill reuses the normal write path, one entry per cycle, so the close logic is shared.
  assign we      = accept | filling;
  assign wdata   = filling ? '0 : s_data;
  assign close   = we && (wr_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      err   <= 1'b0;
    end else begin
      if (filling && close) begin
        state <= ST_LOAD;
      end else if (accept && s_last && (wr_cnt != LAST_IDX)) begin
        state <= ST_FILL;
        err   <= 1'b1;
      end
      if (accept && !s_last && (wr_cnt == LAST_IDX)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign s_ready = ~full[wr_bank] & ~rst;
  assign accept  = s_valid & s_ready;
  assign we      = accept;
  assign wdata   = s_data;
  assign close   = accept && (wr_cnt == LAST_IDX);
`endif

  assign m_valid = full[rd_bank];
  assign rel     = m_valid & m_ready;

  // Close and release always target different banks, so both updates apply together.
  always_comb begin
    full_nxt = full;
    if (rel) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (close) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= '0;
    end else begin
      full <= full_nxt;
      if (we) begin
        wr_cnt <= close ? '0 : wr_cnt + 1'b1;
      end
      if (close) begin
        wr_bank <= ~wr_bank;
      end
      if (rel) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      if (wr_bank) begin
        bank1[wr_cnt] <= wdata;
      end else begin
        bank0[wr_cnt] <= wdata;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < IN; k++) begin
      x[k] = rd_bank ? bank1[k] : bank0[k];
    end
  end

endmodule

// File: tb/tb_fc_in_buffer.sv
// Self-checking bench for fc_in_buffer: directed sequences, a vector table and a randomized run against a frame-queue model.
// Framing-check tests are compiled only when FC_IN_LAST_CHECK_EN is defined.
module tb_fc_in_buffer;

  localparam int N = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] x [0:N-1];
`ifdef FC_IN_LAST_CHECK_EN
  logic       s_last;
  logic       err;
`endif

  always #5 clk = ~clk;

  fc_in_buffer #(.WIDTH(8), .IN(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
`ifdef FC_IN_LAST_CHECK_EN
    .s_last  (s_last),
    .err     (err),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .x       (x)
  );

  int total = 0;
  int bad   = 0;

  // Model: words of the frame being collected, and all complete frames awaiting release, oldest first.
  logic [7:0] cur_q[$];
  logic [7:0] done_q[$];
  bit         filling_m;
  bit         err_m;
  int         rel_cnt;

  function automatic int pending();
    return done_q.size() / N;
  endfunction

  function automatic bit exp_ready();
    return (pending() < 2) && !filling_m;
  endfunction

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int idx;
    check1("s_ready", s_ready, exp_ready());
    check1("m_valid", m_valid, pending() > 0);
    if (pending() > 0) begin
      idx = 0;
      for (int k = 0; k < N; k++) begin
        if (x[k] !== done_q[k]) begin
          idx = k;
          break;
        end
      end
      check1($sformatf("x[%0d]", idx), x[idx], done_q[idx]);
    end
`ifdef FC_IN_LAST_CHECK_EN
    check1("err", err, err_m);
`endif
  endtask

  task automatic model_reset();
    cur_q.delete();
    done_q.delete();
    filling_m = 0;
    err_m     = 0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit mr, output bit acc);
    bit r;
    r   = mr && (pending() > 0);
    acc = v && exp_ready();
    s_valid = v;
    s_data  = d;
    m_ready = mr;
`ifdef FC_IN_LAST_CHECK_EN
    s_last  = l;
`endif
    @(posedge clk);
    if (r) begin
      repeat (N) void'(done_q.pop_front());
      rel_cnt++;
    end
    if (filling_m) begin
      cur_q.push_back(8'h00);
    end else if (acc) begin
      cur_q.push_back(d);
`ifdef FC_IN_LAST_CHECK_EN
      if (l && cur_q.size() < N) begin
        filling_m = 1;
        err_m     = 1;
      end
      if (!l && cur_q.size() == N) err_m = 1;
`endif
    end
    if (cur_q.size() == N) begin
      foreach (cur_q[i]) done_q.push_back(cur_q[i]);
      cur_q.delete();
      filling_m = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
`ifdef FC_IN_LAST_CHECK_EN
    s_last  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_s_ready", s_ready, 0);
    check1("rst_m_valid", m_valid, 0);
    model_reset();
    rst = 1'b0;
    #1;
    check1("s_ready_after_rst", s_ready, 1);
  endtask

  task automatic send_frame(input int base, input int mult, input bit mr);
    bit a;
    for (int k = 0; k < N; k++) step(1'b1, 8'(base + k * mult), k == N - 1, mr, a);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         mr;
    bit         er;
    bit         emv;
    bit         chkx;
    logic [7:0] ex0;
    logic [7:0] ex127;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit         a;
    int         cyc;
    int         rel_base;
    logic [7:0] src[$];

    tbl[0] = '{v:1, d:8'h55, mr:0, er:0, emv:1, chkx:1, ex0:8'h00, ex127:8'h7F};
    tbl[1] = '{v:0, d:8'h00, mr:1, er:1, emv:1, chkx:1, ex0:8'h80, ex127:8'hFF};
    tbl[2] = '{v:0, d:8'h00, mr:1, er:1, emv:0, chkx:0, ex0:8'h00, ex127:8'h00};
    tbl[3] = '{v:0, d:8'h00, mr:1, er:1, emv:0, chkx:0, ex0:8'h00, ex127:8'h00};
    tbl[4] = '{v:1, d:8'h11, mr:0, er:1, emv:0, chkx:0, ex0:8'h00, ex127:8'h00};

    rel_cnt = 0;
    do_reset();

    // Frame 0: x[k]=k, frame 1: 0x80+k, no releases.
    send_frame(0, 1, 0);
    check1("mvalid_after_word127", m_valid, 1);
    check1("f0_x0", x[0], 8'h00);
    check1("f0_x127", x[127], 8'h7F);
    send_frame(8'h80, 1, 0);
    check1("s_ready_both_full", s_ready, 0);
    check1("f0_held_x5", x[5], 8'h05);

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].d, 1'b0, tbl[i].mr, a);
      check1($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].er);
      check1($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].emv);
      if (tbl[i].chkx) begin
        check1($sformatf("tbl%0d_x0", i), x[0], tbl[i].ex0);
        check1($sformatf("tbl%0d_x127", i), x[127], tbl[i].ex127);
      end
    end

    // Closing accept and release on the same edge.
    do_reset();
    for (int k = 0; k < N; k++) step(1'b1, 8'(k) ^ 8'h3C, k == N - 1, 1'b0, a);
    for (int k = 0; k < N - 1; k++) step(1'b1, ~8'(k), 1'b0, 1'b0, a);
    step(1'b1, ~8'(N - 1), 1'b1, 1'b1, a);
    check1("same_edge_m_valid", m_valid, 1);
    check1("same_edge_x0", x[0], 8'hFF);
    step(1'b0, 8'h00, 1'b0, 1'b1, a);
    check1("same_edge_drained", m_valid, 0);
    send_frame(1, 1, 0);
    check1("after_swap_x0", x[0], 8'h01);

    // Reset in the middle of frame 2 with one bank full.
    do_reset();
    send_frame(0, 1, 0);
    for (int k = 0; k < 60; k++) step(1'b1, 8'(k + 9), 1'b0, 1'b0, a);
    do_reset();
    check1("midrst_m_valid", m_valid, 0);
    send_frame(0, 3, 0);
    check1("midrst_x0", x[0], 8'h00);
    check1("midrst_x127", x[127], 8'(381));

    // Randomized: 20 frames, 50% source gaps, throttled release.
    do_reset();
    rel_base = rel_cnt;
    for (int i = 0; i < 20 * N; i++) src.push_back(8'($urandom));
    cyc = 0;
    while ((src.size() > 0 || pending() > 0) && cyc < 20000) begin
      bit v;
      v = (src.size() > 0) && ($urandom_range(1) == 1);
      step(v, (src.size() > 0) ? src[0] : 8'h00, cur_q.size() == N - 1,
           $urandom_range(1) == 1, a);
      if (a) void'(src.pop_front());
      cyc++;
    end
    check1("rand_finished_in_budget", cyc < 20000, 1);
    check1("rand_frames_released", rel_cnt - rel_base, 20);

`ifdef FC_IN_LAST_CHECK_EN
    // Short frame: s_last on word 99 triggers zero-fill and err.
    do_reset();
    for (int k = 0; k < 100; k++) step(1'b1, 8'(k + 1), k == 99, 1'b0, a);
    cyc = 0;
    while (filling_m && cyc < 64) begin
      step(1'b1, 8'hEE, 1'b0, 1'b0, a);
      cyc++;
    end
    check1("fill_in_budget", filling_m, 0);
    check1("short_err", err, 1);
    check1("short_m_valid", m_valid, 1);
    check1("short_x99", x[99], 8'd100);
    check1("short_x100", x[100], 8'h00);
    check1("short_x127", x[127], 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, a);
    send_frame(5, 1, 0);
    check1("err_sticky", err, 1);
    do_reset();
    check1("err_cleared", err, 0);
    send_frame(7, 1, 0);
    check1("good_last_err", err, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, a);
    for (int k = 0; k < N; k++) step(1'b1, 8'(k), 1'b0, 1'b0, a);
    check1("missing_last_err", err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
